pipe_credit_fifo: RTL and testbench



---
 rtl/pipe_credit_fifo.sv | 70 +++++++
 tb/tb_pipe_credit_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_credit_fifo.sv
// pipe_credit_fifo: credit-metered FWFT receive buffer behind a fixed-latency delay line
module pipe_credit_fifo #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 32,
  parameter int DEPTH   = 64,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH),
  localparam int FW = $clog2(LATENCY + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  output logic             issue_rdy_o,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             rd_ready_i,
  output logic [LW-1:0]    level_o,
  output logic [LW-1:0]    credit_o,
  output logic             err_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d, credit_q, credit_d;
  logic [FW-1:0] flush_q, flush_d;
  logic err_q, err_d;
  logic issue, pop, push, full, flush_done;
  assign issue_rdy_o = credit_q != '0;
  assign rd_valid_o  = level_q != '0;
  assign rd_data_o   = mem_q[rd_ptr_q];
  assign level_o     = level_q;
  assign credit_o    = credit_q;
  assign err_o       = err_q;
  // Next-state: credits, occupancy, flush countdown and sticky error; bad events leave state intact
  always_comb begin
    flush_done = flush_q == '0;
    full       = level_q == LW'(DEPTH);
    issue      = issue_i & issue_rdy_o;
    pop        = rd_valid_o & rd_ready_i;
    push       = wr_en_i & flush_done & ~full;
    credit_d   = (issue & ~pop) ? credit_q - LW'(1)
               : (pop & ~issue & credit_q != LW'(DEPTH)) ? credit_q + LW'(1) : credit_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    flush_d    = flush_done ? flush_q : flush_q - FW'(1);
    err_d      = err_q | (issue_i & ~issue_rdy_o) | (wr_en_i & flush_done & full);
  end
  // Control state register; reset restarts the flush window so stale delay-line valids are masked
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      credit_q <= LW'(DEPTH);
      flush_q  <= FW'(LATENCY);
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      level_q  <= level_d;
      credit_q <= credit_d;
      flush_q  <= flush_d;
      err_q    <= err_d;
    end
  end
  // Storage array, unreset; contents are only observed once counted by level
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: tb/tb_pipe_credit_fifo.sv
// tb_pipe_credit_fifo: scoreboard bench with a behavioural delay line feeding the buffer
module tb_pipe_credit_fifo;
  localparam int W = 4, LAT = 4, D = 8, LW = $clog2(D + 1);
  logic clk_i = 0, rst_i = 1, issue_i = 0, rd_ready_i = 0;
  logic issue_rdy_o, wr_en_i, rd_valid_o, err_o;
  logic [W-1:0] wr_data_i, rd_data_o, issue_data = '0;
  logic [LW-1:0] level_o, credit_o;
  logic ovr = 0, ovr_en = 0;
  logic [W-1:0] ovr_data = '0;
  logic dv [LAT];
  logic [W-1:0] dd [LAT];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] nxt = '0;
  int errors = 0, checks = 0, n_iss = 0, n_pop = 0;

  pipe_credit_fifo #(.WIDTH(W), .LATENCY(LAT), .DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_i(issue_i), .issue_rdy_o(issue_rdy_o),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i), .level_o(level_o),
    .credit_o(credit_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    dv[0] <= issue_i & issue_rdy_o;
    dd[0] <= issue_data;
    for (int k = 1; k < LAT; k++) begin
      dv[k] <= dv[k-1];
      dd[k] <= dd[k-1];
    end
  end
  assign wr_en_i   = ovr ? ovr_en : dv[LAT-1];
  assign wr_data_i = ovr ? ovr_data : dd[LAT-1];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input bit iss, input bit frc, input bit rdy);
    logic [W-1:0] e;
    rd_ready_i = rdy;
    issue_i = frc | (iss & issue_rdy_o);
    issue_data = nxt;
    if (issue_i && issue_rdy_o) begin
      exp_q.push_back(nxt);
      nxt++;
      n_iss++;
    end
    if (rd_valid_o && rdy) begin
      checks++;
      n_pop++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got %h with empty scoreboard", rd_data_o);
      end else begin
        e = exp_q.pop_front();
        if (rd_data_o !== e) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h", rd_data_o, e);
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1;
    issue_i = 0;
    rd_ready_i = 0;
    ovr = 0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 0;
    exp_q.delete();
    n_iss = 0;
    n_pop = 0;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic test_reset;
    do_reset(LAT + 2);
    chk("rst_level", level_o, 0);
    chk("rst_credit", credit_o, D);
    chk("rst_issue_rdy", issue_rdy_o, 1);
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_err", err_o, 0);
    ovr = 1;
    ovr_en = 1;
    for (int i = 0; i < LAT; i++) begin
      ovr_data = W'($urandom);
      step(0, 0, 0);
    end
    ovr = 0;
    chk("flush_level", level_o, 0);
    chk("flush_valid", rd_valid_o, 0);
    chk("flush_err", err_o, 0);
    chk("flush_credit", credit_o, D);
  endtask

  task automatic test_stream;
    int first = -1, last = -1, vcnt = 0, min_cr = D;
    do_reset(2);
    for (int i = 0; i < 32; i++) begin
      if (rd_valid_o) begin
        if (first < 0) first = i;
        last = i;
        vcnt++;
      end
      if (credit_o < min_cr) min_cr = credit_o;
      step(i < 20, 0, 1);
    end
    chk("stream_first_valid", first, LAT + 1);
    chk("stream_last_valid", last, LAT + 20);
    chk("stream_valid_cycles", vcnt, 20);
    chk("stream_min_credit", min_cr, D - LAT - 1);
    chk("stream_pops", n_pop, 20);
    chk("stream_credit_end", credit_o, D);
  endtask

  task automatic test_backpressure;
    int fall = -1;
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      if (!issue_rdy_o && fall < 0) fall = i;
      if (i == 12) chk("bp_level_full", level_o, D);
      step(1, 0, 0);
    end
    chk("bp_issues", n_iss, D);
    chk("bp_rdy_fall", fall, D);
    chk("bp_err", err_o, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    chk("bp_pops", n_pop, D);
    chk("bp_credit_back", credit_o, D);
    chk("bp_level_empty", level_o, 0);
  endtask

  task automatic test_credit_boundary;
    do_reset(2);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    chk("cb_credit0", credit_o, 0);
    step(1, 0, 0);
    chk("cb_credit_hold0", credit_o, 0);
    step(1, 0, 1);
    chk("cb_credit_pop", credit_o, 1);
    step(1, 0, 0);
    chk("cb_credit_reissue", credit_o, 0);
    step(0, 0, 1);
    chk("cb_credit_pop2", credit_o, 1);
    step(1, 0, 1);
    chk("cb_credit_both", credit_o, 1);
    chk("cb_err", err_o, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1);
    chk("cb_drain_credit", credit_o, D);
    chk("cb_drain_left", exp_q.size(), 0);
  endtask

  task automatic test_illegal;
    do_reset(2);
    for (int i = 0; i < D; i++) step(1, 0, 0);
    chk("il_credit0", credit_o, 0);
    step(0, 1, 0);
    chk("il_err_set", err_o, 1);
    chk("il_credit_kept", credit_o, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("il_err_sticky", err_o, 1);
    do_reset(1);
    chk("il_err_clear", err_o, 0);
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    do_reset(2);
    for (int i = 0; i < D; i++) step(1, 0, 0);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (level_o == 5) seen = 1;
      else step(0, 0, 0);
    end
    chk("rm_level5_seen", seen, 1);
    do_reset(1);
    chk("rm_level", level_o, 0);
    chk("rm_credit", credit_o, D);
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 0);
    chk("rm_stale_ignored", level_o, 0);
    chk("rm_stale_valid", rd_valid_o, 0);
    for (int i = 0; i < 24; i++) step(i < 10, 0, 1);
    chk("rm_new_pops", n_pop, 10);
    chk("rm_credit_end", credit_o, D);
    chk("rm_err", err_o, 0);
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_credit_boundary;
    test_illegal;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
